cic_comb_ctrl: RTL and testbench
================================

# cic_comb_ctrl

Sequencer and stream wrapper for the DSP48 comb stage of the channelizer CIC (differential delay M, N=1). It accepts an AXI-Stream sample stream and owns the M-deep circular delay memory. It drives the comb's `c` and `concat` operands with the skew that the comb's internal registers require, and collects the comb result `p` into an output FIFO. Credit-based flow control lets the comb, whose clock enables are tied high, run without stalling while the block still honours downstream backpressure.

## Interface
- `M`, 256: comb differential delay in samples; power of two, 2..4096.
- `ADDR_W`, 8: log2(M).
- `FIFO_DEPTH`, 8: output FIFO entries; power of two, ≥ 6.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous reset, active low.
- `s_tdata` in 48: input sample, two's complement.
- `s_tvalid` in 1: input valid.
- `s_tready` out 1: input ready.
- `s_tlast` in 1: frame marker, passed through with its sample.
- `flush` in 1: synchronous restart of the delay line; one cycle is sufficient.
- `dsp_c` out 48: to comb `c`; carries the current sample.
- `dsp_concat` out 48: to comb `concat`; carries the sample from M earlier.
- `dsp_p` in 48: comb result, p = c − concat.
- `m_tdata` out 48: output sample.
- `m_tvalid` out 1: output valid.
- `m_tready` in 1: output ready.
- `m_tlast` out 1: frame marker.
- `primed` out 1: high once M samples have been accepted since reset or flush.

## Operation
- **Accept.** A sample is accepted on any edge where `s_tvalid` and `s_tready` are both high. Call that edge E0.
- **At E0:**
  - `mem[wr_ptr]` is written with `s_tdata`.
  - `rd_q` is loaded with the old value of `mem[wr_ptr]` (read-before-write at the same address).
  - `dsp_c` is loaded with `s_tdata`.
  - `wr_ptr` increments modulo M, wrapping from M−1 to 0.
  - `prime_cnt` increments, saturating at M.
- **At E1:** `dsp_concat` is loaded with `rd_q` if `prime_cnt` was equal to M before E0; otherwise it is loaded with 0. The priming zeros mean the delay memory never needs clearing.
- **Idle cycles.** When no sample is accepted, `dsp_c` and `dsp_concat` hold their values.
- **Valid pipeline.** A 5-stage shift register carries valid and tlast alongside each sample. Stage k is set after E_k.
- **FIFO write.** At E5, `dsp_p` and the stage-5 tlast are written into the output FIFO.
- **Credit counter.** `credit` counts samples in flight plus FIFO occupancy.
  - +1 on input accept.
  - −1 on output handshake.
  - Both on the same edge: net 0.
- **Input ready.** `s_tready` = (`credit` < FIFO_DEPTH) && !`flush`. This guarantees the FIFO never overflows even though the comb cannot stall.
- **Output.** `m_tvalid` is high whenever the FIFO is non-empty. `m_tdata`/`m_tlast` present the FIFO head. The head pops on `m_tvalid` && `m_tready`.
- **Flush.** On an edge with `flush` high, `wr_ptr` and `prime_cnt` are cleared and `primed` drops.
  - Samples already in flight and in the FIFO drain unchanged.
  - No sample is accepted on a flush edge.
- **Arithmetic.** Full 48-bit two's complement, wrapping on overflow as the CIC requires. The block adds no saturation or rounding.
- **Reset** (asynchronous, `rst_n` low) clears:
  - pointers, counters, credit, valid pipeline and FIFO;
  - `dsp_c` = 0, `dsp_concat` = 0;
  - `s_tready` = 0, `m_tvalid` = 0, `m_tdata` = 0, `m_tlast` = 0, `primed` = 0.
  - The contents of `mem` are not reset.
- **Reset mid-stream** discards all in-flight samples. The first post-reset output is computed against zeros.

## Timing
- **Latency.** From accept edge E0, `m_tvalid` goes high after E5 when the FIFO is empty and `m_tready` is high. That is 5 cycles.
- **Operand skew.** `dsp_c` leads `dsp_concat` by exactly one cycle. This matches the comb's 4-register `c` path against its 3-register `concat` path, so both meet at the comb's P register on E4.
- **Throughput.** One sample per clock sustained while `m_tready` is held high, given FIFO_DEPTH ≥ 6.
- **First ready.** `s_tready` rises on the first edge after `rst_n` deasserts.
- **Primed.** `primed` rises on the edge of the M-th accept.

## Test plan
- **Impulse response.** Stimulus: `s_tdata` = 1, then 300 zeros, continuous valid, `m_tready` = 1. Required: output 0 = 1; outputs 1..255 = 0; output 256 = 48'hFFFF_FFFF_FFFF (−1); outputs 257.. = 0; first `m_tvalid` exactly 5 cycles after accept.
- **Ramp.** Stimulus: `s_tdata` = n for n = 0..599. Required: outputs 0..255 = n (priming zeros); outputs 256.. = 256; `primed` rises at accept 256.
- **Backpressure.** Stimulus: 1000-sample ramp; `m_tready` random at 30 % high; `s_tvalid` random. Required: outputs match the reference model; no loss or duplication; `credit` never exceeds FIFO_DEPTH; `s_tready` low whenever `credit` = FIFO_DEPTH.
- **Flush.** Stimulus: pulse `flush` after 400 samples of value 5. Required: the 5 in-flight results still equal 0; the next 256 outputs equal 5; the following outputs equal 0; `primed` drops on the flush edge; no accept on that edge.
- **Async reset mid-stream.** Stimulus: drop `rst_n` for 3 cycles while the FIFO holds 4 entries. Required: `m_tvalid` = 0 and `s_tready` = 0 immediately; after release, an impulse reproduces the impulse-response result.
- **Wrap and tlast.** Stimulus: M = 4 build; frames of 7 samples with `s_tlast` on the last sample. Required: `m_tlast` aligns with output index 6 of each frame; delay = 4 is correct across pointer wrap.

Source files
------------

// File: rtl/cic_comb_ctrl.sv
// Stream wrapper for the DSP48 CIC comb stage: owns the M-deep delay line and skews c/concat.
// Latency 5 cycles accept-to-m_tvalid; a credit counter throttles s_tready so the free-running comb never overflows the FIFO.

module cic_comb_fifo #(
    parameter int W     = 49,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         full;

    assign rd_vld = (wr_ptr_q != rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_vld) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_dat;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (rd_vld && rd_rdy) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // The upstream credit scheme is what makes this impossible; trap it if it ever breaks.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(wr_vld && full));

endmodule

module cic_comb_ctrl #(
    parameter int M          = 256,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic        s_tlast,
    input  logic        flush,
    output logic [47:0] dsp_c,
    output logic [47:0] dsp_concat,
    input  logic [47:0] dsp_p,
    output logic [47:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        primed
);
    localparam int                CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W:0]   PRIME_MAX  = (ADDR_W+1)'(M);
    localparam logic [CW-1:0]     CREDIT_MAX = CW'(FIFO_DEPTH);

    logic              init_q, init_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   prime_cnt_q, prime_cnt_d;
    logic              sel_q, sel_d;
    logic [47:0]       dsp_c_q, dsp_c_d;
    logic [47:0]       dsp_concat_q, dsp_concat_d;
    logic [4:0]        vld_q, vld_d;
    logic [4:0]        last_q, last_d;
    logic [CW-1:0]     credit_q, credit_d;

    logic [47:0]       mem [M];
    logic [47:0]       rd_q;

    logic              accept;
    logic              pop;
    logic              fifo_vld;
    logic [48:0]       fifo_dat;

    assign s_tready   = init_q && (credit_q < CREDIT_MAX) && !flush;
    assign accept     = s_tvalid && s_tready;
    assign pop        = fifo_vld && m_tready;
    assign dsp_c      = dsp_c_q;
    assign dsp_concat = dsp_concat_q;
    assign primed     = (prime_cnt_q == PRIME_MAX);
    assign m_tvalid   = fifo_vld;
    assign m_tdata    = fifo_dat[47:0];
    assign m_tlast    = fifo_dat[48];

    // Read-before-write at one address gives the sample from M accepts ago.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_q          <= mem[wr_ptr_q];
            mem[wr_ptr_q] <= s_tdata;
        end
    end

    always_comb begin
        init_d       = 1'b1;
        wr_ptr_d     = wr_ptr_q;
        prime_cnt_d  = prime_cnt_q;
        sel_d        = sel_q;
        dsp_c_d      = dsp_c_q;
        dsp_concat_d = dsp_concat_q;
        vld_d        = {vld_q[3:0], accept};
        last_d       = {last_q[3:0], accept && s_tlast};
        credit_d     = credit_q + CW'(accept) - CW'(pop);

        if (flush) begin
            wr_ptr_d    = '0;
            prime_cnt_d = '0;
        end else if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (prime_cnt_q != PRIME_MAX) begin
                prime_cnt_d = prime_cnt_q + 1'b1;
            end
        end

        if (accept) begin
            sel_d   = (prime_cnt_q == PRIME_MAX);
            dsp_c_d = s_tdata;
        end

        // concat trails c by one cycle; zeros stand in until the line is primed.
        if (vld_q[0]) begin
            dsp_concat_d = sel_q ? rd_q : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q       <= 1'b0;
            wr_ptr_q     <= '0;
            prime_cnt_q  <= '0;
            sel_q        <= 1'b0;
            dsp_c_q      <= '0;
            dsp_concat_q <= '0;
            vld_q        <= '0;
            last_q       <= '0;
            credit_q     <= '0;
        end else begin
            init_q       <= init_d;
            wr_ptr_q     <= wr_ptr_d;
            prime_cnt_q  <= prime_cnt_d;
            sel_q        <= sel_d;
            dsp_c_q      <= dsp_c_d;
            dsp_concat_q <= dsp_concat_d;
            vld_q        <= vld_d;
            last_q       <= last_d;
            credit_q     <= credit_d;
        end
    end

    cic_comb_fifo #(
        .W     (49),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (vld_q[4]),
        .wr_dat ({last_q[4], dsp_p}),
        .rd_vld (fifo_vld),
        .rd_rdy (m_tready),
        .rd_dat (fifo_dat)
    );

    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n) credit_q <= CREDIT_MAX);

endmodule

// File: tb/tb_cic_comb_ctrl.sv
// Directed bench for cic_comb_ctrl: M=256 instance for stream behaviour, M=4 instance for wrap/tlast.
module tb_cic_comb_ctrl;
    localparam int M = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [47:0] s_tdata;
    logic        s_tvalid, s_tready, s_tlast, flush;
    logic [47:0] dsp_c, dsp_concat, dsp_p;
    logic [47:0] m_tdata;
    logic        m_tvalid, m_tready, m_tlast, primed;

    logic [47:0] s_tdata4;
    logic        s_tvalid4, s_tready4, s_tlast4;
    logic [47:0] dsp_c4, dsp_concat4, dsp_p4;
    logic [47:0] m_tdata4;
    logic        m_tvalid4, m_tready4, m_tlast4, primed4;

    cic_comb_ctrl #(.M(256), .ADDR_W(8), .FIFO_DEPTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .flush(flush), .dsp_c(dsp_c), .dsp_concat(dsp_concat), .dsp_p(dsp_p),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .primed(primed)
    );

    cic_comb_ctrl #(.M(4), .ADDR_W(2), .FIFO_DEPTH(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata4), .s_tvalid(s_tvalid4), .s_tready(s_tready4),
        .s_tlast(s_tlast4), .flush(1'b0), .dsp_c(dsp_c4), .dsp_concat(dsp_concat4), .dsp_p(dsp_p4),
        .m_tdata(m_tdata4), .m_tvalid(m_tvalid4), .m_tready(m_tready4), .m_tlast(m_tlast4), .primed(primed4)
    );

    // DSP48 comb: c through 3 regs, concat through 2 regs, meeting at the P register.
    logic [47:0] c1 = '0, c2 = '0, c3 = '0, a1 = '0, a2 = '0;
    logic [47:0] k1 = '0, k2 = '0, k3 = '0, b1 = '0, b2 = '0;
    initial begin dsp_p = '0; dsp_p4 = '0; end
    always @(posedge clk) begin
        c1 <= dsp_c;  c2 <= c1; c3 <= c2; a1 <= dsp_concat;  a2 <= a1; dsp_p  <= c3 - a2;
        k1 <= dsp_c4; k2 <= k1; k3 <= k2; b1 <= dsp_concat4; b2 <= b1; dsp_p4 <= k3 - b2;
    end

    int checks = 0, passed = 0;
    int cyc = 0;
    int acc_cnt = 0, first_acc = -1, last_acc = -1, first_vld = -1;
    int tmo = 0, bp_viol = 0;
    bit bp_mode = 1'b0;
    logic [48:0] out_q[$];
    logic [48:0] out4_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bp_mode) m_tready = ($urandom_range(0, 9) < 3);
    end

    // Observe handshakes that will complete on the coming rising edge.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (s_tvalid && s_tready) begin
                if (first_acc < 0) first_acc = cyc + 1;
                last_acc = cyc + 1;
                acc_cnt++;
            end
            if (m_tvalid && first_vld < 0) first_vld = cyc;
            if (m_tvalid && m_tready) out_q.push_back({m_tlast, m_tdata});
            if (m_tvalid4 && m_tready4) out4_q.push_back({m_tlast4, m_tdata4});
            if (bp_mode && (u_dut.credit_q > 8 || (u_dut.credit_q == 8 && s_tready))) bp_viol++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; flush = 1'b0; s_tdata = '0;
        repeat (3) @(negedge clk);
        out_q.delete(); acc_cnt = 0; first_acc = -1; last_acc = -1; first_vld = -1;
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [47:0] d, input logic l);
        int n = 0;
        bit ok = 1'b0;
        s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
        while (!ok && n < 500) begin
            #1; ok = s_tready;
            @(negedge clk); n++;
        end
        s_tvalid = 1'b0;
        if (!ok) tmo++;
    endtask

    task automatic wait_outs(input int n);
        int c = 0;
        while (out_q.size() < n && c < 5000) begin @(negedge clk); c++; end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (s_tready !== 1'b0) $display("FAIL reset_s_tready: got %b want 0", s_tready); else passed++;
        checks++; if (m_tvalid !== 1'b0) $display("FAIL reset_m_tvalid: got %b want 0", m_tvalid); else passed++;
        checks++; if (m_tdata !== 48'd0) $display("FAIL reset_m_tdata: got %h want 0", m_tdata); else passed++;
        checks++; if (m_tlast !== 1'b0) $display("FAIL reset_m_tlast: got %b want 0", m_tlast); else passed++;
        checks++; if (primed !== 1'b0) $display("FAIL reset_primed: got %b want 0", primed); else passed++;
        checks++; if (dsp_c !== 48'd0) $display("FAIL reset_dsp_c: got %h want 0", dsp_c); else passed++;
        checks++; if (dsp_concat !== 48'd0) $display("FAIL reset_dsp_concat: got %h want 0", dsp_concat); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (s_tready !== 1'b0) $display("FAIL ready_before_edge: got %b want 0", s_tready); else passed++;
        @(negedge clk); #1;
        checks++; if (s_tready !== 1'b1) $display("FAIL ready_first_edge: got %b want 1", s_tready); else passed++;
    endtask

    task automatic run_impulse(input string tag);
        logic [47:0] exp;
        out_q.delete(); first_acc = -1; first_vld = -1; tmo = 0;
        m_tready = 1'b1;
        send(48'd1, 1'b0);
        for (int i = 0; i < 300; i++) send(48'd0, 1'b0);
        wait_outs(301);
        repeat (10) @(negedge clk);
        checks++; if (first_vld - first_acc != 5)
            $display("FAIL %s_latency: got %0d want 5", tag, first_vld - first_acc); else passed++;
        checks++; if (out_q.size() != 301 || tmo != 0)
            $display("FAIL %s_count: got %0d outs (%0d timeouts) want 301", tag, out_q.size(), tmo); else passed++;
        if (out_q.size() >= 301) begin
            for (int i = 0; i < 301; i++) begin
                exp = (i == 0) ? 48'd1 : (i == M) ? 48'hFFFF_FFFF_FFFF : 48'd0;
                checks++; if (out_q[i][47:0] !== exp)
                    $display("FAIL %s_out[%0d]: got %h want %h", tag, i, out_q[i][47:0], exp); else passed++;
            end
        end
    endtask

    task automatic test_impulse();
        do_reset();
        run_impulse("impulse");
    endtask

    task automatic test_ramp();
        logic [47:0] exp;
        do_reset();
        m_tready = 1'b1; tmo = 0;
        for (int n = 0; n < 600; n++) begin
            send(48'(n), 1'b0);
            if (n == 254) begin
                checks++; if (primed !== 1'b0) $display("FAIL ramp_primed_early: got %b want 0", primed); else passed++;
            end
            if (n == 255) begin
                checks++; if (primed !== 1'b1) $display("FAIL ramp_primed_rise: got %b want 1", primed); else passed++;
            end
        end
        wait_outs(600);
        checks++; if (last_acc - first_acc != 599 || tmo != 0)
            $display("FAIL ramp_throughput: got span %0d want 599", last_acc - first_acc); else passed++;
        checks++; if (out_q.size() != 600) $display("FAIL ramp_count: got %0d want 600", out_q.size()); else passed++;
        if (out_q.size() >= 600) begin
            for (int n = 0; n < 600; n++) begin
                exp = (n < M) ? 48'(n) : 48'd256;
                checks++; if (out_q[n][47:0] !== exp)
                    $display("FAIL ramp_out[%0d]: got %0d want %0d", n, out_q[n][47:0], exp); else passed++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [47:0] exp;
        do_reset();
        tmo = 0; bp_viol = 0; bp_mode = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(48'(n), 1'b0);
        end
        bp_mode = 1'b0;
        m_tready = 1'b1;
        wait_outs(1000);
        repeat (10) @(negedge clk);
        checks++; if (bp_viol != 0 || tmo != 0)
            $display("FAIL bp_credit: got %0d violations %0d timeouts want 0", bp_viol, tmo); else passed++;
        checks++; if (out_q.size() != 1000) $display("FAIL bp_count: got %0d want 1000", out_q.size()); else passed++;
        if (out_q.size() >= 1000) begin
            for (int n = 0; n < 1000; n++) begin
                exp = 48'(n) - ((n >= M) ? 48'(n - M) : 48'd0);
                checks++; if (out_q[n][47:0] !== exp)
                    $display("FAIL bp_out[%0d]: got %0d want %0d", n, out_q[n][47:0], exp); else passed++;
            end
        end
    endtask

    task automatic test_flush();
        int a0;
        logic [47:0] exp;
        do_reset();
        m_tready = 1'b1; tmo = 0;
        for (int n = 0; n < 400; n++) send(48'd5, 1'b0);
        checks++; if (primed !== 1'b1) $display("FAIL flush_primed_before: got %b want 1", primed); else passed++;
        a0 = acc_cnt;
        flush = 1'b1; s_tvalid = 1'b1; s_tdata = 48'd5;
        #1;
        checks++; if (s_tready !== 1'b0) $display("FAIL flush_ready: got %b want 0", s_tready); else passed++;
        @(negedge clk);
        flush = 1'b0; s_tvalid = 1'b0;
        checks++; if (primed !== 1'b0) $display("FAIL flush_primed_drop: got %b want 0", primed); else passed++;
        checks++; if (acc_cnt != a0) $display("FAIL flush_no_accept: got %0d want %0d", acc_cnt, a0); else passed++;
        for (int n = 0; n < 300; n++) send(48'd5, 1'b0);
        wait_outs(700);
        checks++; if (out_q.size() != 700 || tmo != 0)
            $display("FAIL flush_count: got %0d want 700", out_q.size()); else passed++;
        if (out_q.size() >= 700) begin
            for (int i = 0; i < 700; i++) begin
                exp = (i < 256 || (i >= 400 && i < 656)) ? 48'd5 : 48'd0;
                checks++; if (out_q[i][47:0] !== exp)
                    $display("FAIL flush_out[%0d]: got %0d want %0d", i, out_q[i][47:0], exp); else passed++;
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_tready = 1'b0; tmo = 0;
        for (int i = 0; i < 4; i++) send(48'(7 + i), 1'b0);
        repeat (8) @(negedge clk);
        checks++; if (m_tvalid !== 1'b1) $display("FAIL midrst_fifo_full: got %b want 1", m_tvalid); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (m_tvalid !== 1'b0) $display("FAIL midrst_m_tvalid: got %b want 0", m_tvalid); else passed++;
        checks++; if (s_tready !== 1'b0) $display("FAIL midrst_s_tready: got %b want 0", s_tready); else passed++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_impulse("midrst_impulse");
    endtask

    task automatic test_wrap_tlast();
        logic [47:0] x[21];
        logic [47:0] exp;
        int n, c;
        bit ok;
        m_tready4 = 1'b1; out4_q.delete();
        for (int i = 0; i < 21; i++) x[i] = (i % 2 == 1) ? (48'd0 - 48'(i * 5)) : 48'(i * i + 3);
        @(negedge clk);
        for (int i = 0; i < 21; i++) begin
            s_tdata4 = x[i]; s_tlast4 = (i % 7 == 6); s_tvalid4 = 1'b1;
            ok = 1'b0; n = 0;
            while (!ok && n < 100) begin #1; ok = s_tready4; @(negedge clk); n++; end
            if (!ok) tmo++;
        end
        s_tvalid4 = 1'b0; s_tlast4 = 1'b0;
        c = 0;
        while (out4_q.size() < 21 && c < 200) begin @(negedge clk); c++; end
        checks++; if (out4_q.size() != 21) $display("FAIL wrap_count: got %0d want 21", out4_q.size()); else passed++;
        if (out4_q.size() >= 21) begin
            for (int i = 0; i < 21; i++) begin
                exp = x[i] - ((i >= 4) ? x[i - 4] : 48'd0);
                checks++; if (out4_q[i][47:0] !== exp)
                    $display("FAIL wrap_out[%0d]: got %h want %h", i, out4_q[i][47:0], exp); else passed++;
                checks++; if (out4_q[i][48] !== (i % 7 == 6))
                    $display("FAIL wrap_tlast[%0d]: got %b want %b", i, out4_q[i][48], (i % 7 == 6)); else passed++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; flush = 1'b0; m_tready = 1'b0;
        s_tdata4 = '0; s_tvalid4 = 1'b0; s_tlast4 = 1'b0; m_tready4 = 1'b0;
        test_reset();
        test_impulse();
        test_ramp();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_wrap_tlast();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
